// File: rtl/adxl_spi_responder_if.sv
// SPI bus bundle between the ADXL-style controller and its responder.
// The master modport is the controller end; the slave modport is the responder end.
interface adxl_spi_responder_if;
    logic SPI_SCLK;
    logic SPI_CS;
    logic SPI_MOSI;
    logic SPI_MISO;

    modport master (output SPI_SCLK, output SPI_CS, output SPI_MOSI, input SPI_MISO);
    modport slave  (input SPI_SCLK, input SPI_CS, input SPI_MOSI, output SPI_MISO);
endinterface

// File: rtl/adxl_spi_responder.sv
// Mode-0 SPI responder emulating the accelerometer register protocol (0x0A write, 0x0B read).
// Define ADXL_SPI_AUTO_INC_EN for burst mode: the address advances after every data byte.
module adxl_spi_responder #(
    parameter int         REG_DEPTH = 64,
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic                      clk,
    input  logic                      rst,
    adxl_spi_responder_if.slave       spi,
    output logic                      wr_strobe,
    output logic [7:0]                wr_addr,
    output logic [7:0]                wr_data,
    output logic                      busy
);
    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_WADDR, ST_WDATA, ST_RADDR, ST_RDATA, ST_IGNORE
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [2:0]      sclk_pipe_r, cs_pipe_r;
    logic [1:0]      mosi_pipe_r;
    logic [2:0]      bit_cnt_r;
    logic [7:0]      rx_shift_r, tx_shift_r, addr_r, rd_data_s, rx_byte_s;
    logic            load_pending_r, busy_r, wr_strobe_r;
    logic [7:0]      wr_addr_r, wr_data_r;
    logic [7:0]      regs_r [REG_DEPTH];
    logic [AW-1:0]   addr_idx_s;
    logic            sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s, cs_low_s, byte_done_s;
    logic            latch_addr_s, commit_s, advance_s, load_set_s, in_range_s, writable_s;

    // Index [1] is the synchronized level, index [2] its previous value.
    assign sclk_rise_s = sclk_pipe_r[1] & ~sclk_pipe_r[2];
    assign sclk_fall_s = ~sclk_pipe_r[1] & sclk_pipe_r[2];
    assign cs_fall_s   = ~cs_pipe_r[1] & cs_pipe_r[2];
    assign cs_rise_s   = cs_pipe_r[1] & ~cs_pipe_r[2];
    assign cs_low_s    = ~cs_pipe_r[1];
    assign byte_done_s = sclk_rise_s && cs_low_s && (bit_cnt_r == 3'd7);
    assign rx_byte_s   = {rx_shift_r[6:0], mosi_pipe_r[1]};
    assign addr_idx_s  = addr_r[AW-1:0];
    assign in_range_s  = ({1'b0, addr_r} < 9'(REG_DEPTH));
    assign writable_s  = in_range_s && (addr_r > 8'h02);

    assign spi.SPI_MISO = tx_shift_r[7];
    assign wr_strobe    = wr_strobe_r;
    assign wr_addr      = wr_addr_r;
    assign wr_data      = wr_data_r;
    assign busy         = busy_r;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe_r <= 3'b000;
            cs_pipe_r   <= 3'b111;
            mosi_pipe_r <= 2'b00;
        end else begin
            sclk_pipe_r <= {sclk_pipe_r[1:0], spi.SPI_SCLK};
            cs_pipe_r   <= {cs_pipe_r[1:0], spi.SPI_CS};
            mosi_pipe_r <= {mosi_pipe_r[0], spi.SPI_MOSI};
        end
    end

    // Protocol state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state decode and per-byte action strobes; CS edges override byte events.
    always_comb begin
        state_nxt_s  = state_r;
        latch_addr_s = 1'b0;
        commit_s     = 1'b0;
        advance_s    = 1'b0;
        load_set_s   = 1'b0;
        if (cs_rise_s) begin
            state_nxt_s = ST_IDLE;
        end else if (cs_fall_s) begin
            state_nxt_s = ST_CMD;
        end else if (byte_done_s) begin
            case (state_r)
                ST_CMD: begin
                    if (rx_byte_s == 8'h0A)      state_nxt_s = ST_WADDR;
                    else if (rx_byte_s == 8'h0B) state_nxt_s = ST_RADDR;
                    else                         state_nxt_s = ST_IGNORE;
                end
                ST_WADDR: begin
                    latch_addr_s = 1'b1;
                    state_nxt_s  = ST_WDATA;
                end
                ST_RADDR: begin
                    latch_addr_s = 1'b1;
                    load_set_s   = 1'b1;
                    state_nxt_s  = ST_RDATA;
                end
                ST_WDATA: begin
                    commit_s  = 1'b1;
                    advance_s = 1'b1;
                end
                ST_RDATA: begin
                    advance_s  = 1'b1;
                    load_set_s = 1'b1;
                end
                default: state_nxt_s = state_r;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Receive shifter and bit counter; any CS edge discards a partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
        end else if (cs_rise_s || cs_fall_s) begin
            bit_cnt_r  <= 3'd0;
            rx_shift_r <= 8'h00;
        end else if (sclk_rise_s && cs_low_s) begin
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            rx_shift_r <= rx_byte_s;
        end
    end

    // Register address: latched from the address byte, optionally advanced per data byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= 8'h00;
        end else if (latch_addr_s) begin
            addr_r <= rx_byte_s;
        end else if (advance_s) begin
`ifdef ADXL_SPI_AUTO_INC_EN
            addr_r <= addr_r + 8'd1;
`else
            addr_r <= addr_r;
`endif
        end
    end

    // Read mux: identification bytes, writable storage, zero above the implemented range.
    always_comb begin
        rd_data_s = 8'h00;
        case (addr_r)
            8'h00:   rd_data_s = DEVID_AD;
            8'h01:   rd_data_s = DEVID_MST;
            8'h02:   rd_data_s = PARTID;
            default: begin
                if (in_range_s) rd_data_s = regs_r[addr_idx_s];
                else            rd_data_s = 8'h00;
            end
        endcase
    end

    // Transmit shifter: loads on the falling edge after a byte boundary so bit 7 leads the next rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift_r     <= 8'h00;
            load_pending_r <= 1'b0;
        end else if (cs_rise_s || cs_fall_s) begin
            tx_shift_r     <= 8'h00;
            load_pending_r <= 1'b0;
        end else if (load_set_s) begin
            load_pending_r <= 1'b1;
        end else if (sclk_fall_s && load_pending_r) begin
            tx_shift_r     <= rd_data_s;
            load_pending_r <= 1'b0;
        end else if (sclk_fall_s) begin
            tx_shift_r     <= {tx_shift_r[6:0], 1'b0};
        end
    end

    // Writable register file; identification and out-of-range addresses ignore writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_DEPTH; i++) regs_r[i] <= 8'h00;
        end else if (commit_s && writable_s) begin
            regs_r[addr_idx_s] <= rx_byte_s;
        end
    end

    // Write-observation outputs and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_strobe_r <= 1'b0;
            wr_addr_r   <= 8'h00;
            wr_data_r   <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            wr_strobe_r <= commit_s;
            if (commit_s) begin
                wr_addr_r <= addr_r;
                wr_data_r <= rx_byte_s;
            end
            if (cs_fall_s)      busy_r <= 1'b1;
            else if (cs_rise_s) busy_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed bench for adxl_spi_responder: bit-banged mode-0 frames with hand-computed expectations.
module tb_adxl_spi_responder;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_strobe;
    logic [7:0] wr_addr, wr_data;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    int         strobe_cnt = 0;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];

    always #5 clk = ~clk;

    adxl_spi_responder_if spi ();

    adxl_spi_responder dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi.SPI_MOSI = tx[i];
            wait_clk(HALF);
            rx[i] = spi.SPI_MISO;
            spi.SPI_SCLK = 1'b1;
            wait_clk(HALF);
            spi.SPI_SCLK = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n);
        logic [7:0] r;
        spi.SPI_CS = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < n; k++) begin
            spi_byte(tx_buf[k], r);
            rx_buf[k] = r;
        end
        wait_clk(HALF);
        spi.SPI_CS   = 1'b1;
        spi.SPI_MOSI = 1'b0;
        wait_clk(2 * HALF);
    endtask

    task automatic spi_read(input logic [7:0] addr, input int nbytes);
        tx_buf[0] = 8'h0B;
        tx_buf[1] = addr;
        for (int k = 2; k < 8; k++) tx_buf[k] = 8'h00;
        spi_frame(nbytes + 2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        spi.SPI_CS = 1'b1; spi.SPI_SCLK = 1'b0; spi.SPI_MOSI = 1'b0;
        wait_clk(4);
        checks++; if (spi.SPI_MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", spi.SPI_MISO); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_devid_read();
        int s0 = strobe_cnt;
        logic [7:0] r;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b expected 0", busy); end
        spi.SPI_CS = 1'b0;
        wait_clk(HALF);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_cs_low: got %b expected 1", busy); end
        spi_byte(8'h0B, r); rx_buf[0] = r;
        spi_byte(8'h00, r); rx_buf[1] = r;
        spi_byte(8'h00, r); rx_buf[2] = r;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_frame_end: got %b expected 1", busy); end
        wait_clk(HALF);
        spi.SPI_CS = 1'b1;
        wait_clk(2 * HALF);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_cs_high: got %b expected 0", busy); end
        checks++; if (rx_buf[0] !== 8'h00 || rx_buf[1] !== 8'h00) begin errors++; $display("FAIL miso_cmd_addr: got %h %h expected 00 00", rx_buf[0], rx_buf[1]); end
        checks++; if (rx_buf[2] !== 8'hAD) begin errors++; $display("FAIL read_devid_ad: got %h expected ad", rx_buf[2]); end
        spi_read(8'h01, 1);
        checks++; if (rx_buf[2] !== 8'h1D) begin errors++; $display("FAIL read_devid_mst: got %h expected 1d", rx_buf[2]); end
        spi_read(8'h02, 1);
        checks++; if (rx_buf[2] !== 8'hF2) begin errors++; $display("FAIL read_partid: got %h expected f2", rx_buf[2]); end
        spi_read(8'h40, 1);
        checks++; if (rx_buf[2] !== 8'h00) begin errors++; $display("FAIL read_out_of_range: got %h expected 00", rx_buf[2]); end
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL read_no_strobe: got %0d expected %0d", strobe_cnt, s0); end
    endtask

    task automatic test_write_read();
        int s0 = strobe_cnt;
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'h02;
        spi_frame(3);
        checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL write_strobe_cnt: got %0d expected %0d", strobe_cnt, s0 + 1); end
        checks++; if (wr_addr !== 8'h2D) begin errors++; $display("FAIL write_addr: got %h expected 2d", wr_addr); end
        checks++; if (wr_data !== 8'h02) begin errors++; $display("FAIL write_data: got %h expected 02", wr_data); end
        spi_read(8'h2D, 1);
        checks++; if (rx_buf[2] !== 8'h02) begin errors++; $display("FAIL readback_2d: got %h expected 02", rx_buf[2]); end
    endtask

    task automatic test_readonly_write();
        int s0 = strobe_cnt;
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h01; tx_buf[2] = 8'h55;
        spi_frame(3);
        checks++; if (strobe_cnt !== s0 + 1) begin errors++; $display("FAIL ro_strobe_cnt: got %0d expected %0d", strobe_cnt, s0 + 1); end
        checks++; if (wr_addr !== 8'h01 || wr_data !== 8'h55) begin errors++; $display("FAIL ro_wr_obs: got %h/%h expected 01/55", wr_addr, wr_data); end
        spi_read(8'h01, 1);
        checks++; if (rx_buf[2] !== 8'h1D) begin errors++; $display("FAIL ro_readback: got %h expected 1d", rx_buf[2]); end
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h50; tx_buf[2] = 8'h77;
        spi_frame(3);
        checks++; if (wr_addr !== 8'h50 || wr_data !== 8'h77) begin errors++; $display("FAIL oor_wr_obs: got %h/%h expected 50/77", wr_addr, wr_data); end
        spi_read(8'h50, 1);
        checks++; if (rx_buf[2] !== 8'h00) begin errors++; $display("FAIL oor_readback: got %h expected 00", rx_buf[2]); end
    endtask

    task automatic test_burst();
        int s0 = strobe_cnt;
        logic [7:0] exp_last_addr, exp_wrap_addr;
        logic [7:0] exp_rd [3];
`ifdef ADXL_SPI_AUTO_INC_EN
        exp_last_addr = 8'h22; exp_wrap_addr = 8'h00;
        exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33;
`else
        exp_last_addr = 8'h20; exp_wrap_addr = 8'hFF;
        exp_rd[0] = 8'h33; exp_rd[1] = 8'h33; exp_rd[2] = 8'h33;
`endif
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h20; tx_buf[2] = 8'h11; tx_buf[3] = 8'h22; tx_buf[4] = 8'h33;
        spi_frame(5);
        checks++; if (strobe_cnt !== s0 + 3) begin errors++; $display("FAIL burst_strobe_cnt: got %0d expected %0d", strobe_cnt, s0 + 3); end
        checks++; if (wr_addr !== exp_last_addr || wr_data !== 8'h33) begin errors++; $display("FAIL burst_wr_obs: got %h/%h expected %h/33", wr_addr, wr_data, exp_last_addr); end
        spi_read(8'h20, 3);
        for (int k = 0; k < 3; k++) begin
            checks++; if (rx_buf[k+2] !== exp_rd[k]) begin errors++; $display("FAIL burst_read%0d: got %h expected %h", k, rx_buf[k+2], exp_rd[k]); end
        end
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'hFF; tx_buf[2] = 8'h01; tx_buf[3] = 8'h02;
        spi_frame(4);
        checks++; if (wr_addr !== exp_wrap_addr || wr_data !== 8'h02) begin errors++; $display("FAIL addr_wrap: got %h/%h expected %h/02", wr_addr, wr_data, exp_wrap_addr); end
    endtask

    task automatic test_partial_abort();
        int s0;
        logic [7:0] r;
        tx_buf[0] = 8'h0A; tx_buf[1] = 8'h10; tx_buf[2] = 8'h5A;
        spi_frame(3);
        s0 = strobe_cnt;
        spi.SPI_CS = 1'b0;
        wait_clk(HALF);
        spi_byte(8'h0A, r);
        spi_byte(8'h10, r);
        for (int i = 0; i < 4; i++) begin
            spi.SPI_MOSI = 1'b1;
            wait_clk(HALF);
            spi.SPI_SCLK = 1'b1;
            wait_clk(HALF);
            spi.SPI_SCLK = 1'b0;
        end
        wait_clk(HALF);
        spi.SPI_CS = 1'b1; spi.SPI_MOSI = 1'b0;
        wait_clk(2 * HALF);
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL partial_no_strobe: got %0d expected %0d", strobe_cnt, s0); end
        spi_read(8'h10, 1);
        checks++; if (rx_buf[2] !== 8'h5A) begin errors++; $display("FAIL partial_reg_kept: got %h expected 5a", rx_buf[2]); end
    endtask

    task automatic test_ignore_and_reset();
        int s0 = strobe_cnt;
        logic [7:0] r;
        tx_buf[0] = 8'h07; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        spi_frame(3);
        checks++; if (rx_buf[1] !== 8'h00 || rx_buf[2] !== 8'h00) begin errors++; $display("FAIL ignore_miso: got %h %h expected 00 00", rx_buf[1], rx_buf[2]); end
        checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL ignore_no_strobe: got %0d expected %0d", strobe_cnt, s0); end
        spi.SPI_CS = 1'b0;
        wait_clk(HALF);
        spi_byte(8'h0B, r);
        spi_byte(8'h2D, r);
        spi.SPI_MOSI = 1'b0;
        wait_clk(HALF);
        spi.SPI_SCLK = 1'b1;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(3);
        checks++; if (spi.SPI_MISO !== 1'b0) begin errors++; $display("FAIL midrst_miso: got %b expected 0", spi.SPI_MISO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (wr_strobe !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 8'h00) begin errors++; $display("FAIL midrst_wr_obs: got %b/%h/%h expected 0/00/00", wr_strobe, wr_addr, wr_data); end
        spi.SPI_SCLK = 1'b0; spi.SPI_CS = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        spi_read(8'h2D, 1);
        checks++; if (rx_buf[2] !== 8'h00) begin errors++; $display("FAIL rst_clears_2d: got %h expected 00", rx_buf[2]); end
        spi_read(8'h10, 1);
        checks++; if (rx_buf[2] !== 8'h00) begin errors++; $display("FAIL rst_clears_10: got %h expected 00", rx_buf[2]); end
        spi_read(8'h00, 1);
        checks++; if (rx_buf[2] !== 8'hAD) begin errors++; $display("FAIL devid_after_rst: got %h expected ad", rx_buf[2]); end
    endtask

    initial begin
        spi.SPI_CS = 1'b1;
        spi.SPI_SCLK = 1'b0;
        spi.SPI_MOSI = 1'b0;
        test_reset();
        test_devid_read();
        test_write_read();
        test_readonly_write();
        test_burst();
        test_partial_abort();
        test_ignore_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adxl_spi_responder.md
Name: adxl_spi_responder

Overview:
- SPI mode-0 responder (peripheral end) modelling the accelerometer's register-access protocol: write command 0x0A and read command 0x0B, each followed by an address byte and one or more data bytes.
- Used as the bus partner for the SPI controller in simulation, and as a loopback target on the board (driven from a second Pmod).
- Samples the asynchronous SCLK, CS and MOSI lines on the system clock and holds a small byte-wide register file.

Parameters:
- REG_DEPTH, 64: number of implemented byte registers, at addresses 0..REG_DEPTH-1 (power of two, ≤256).
- DEVID_AD, 8'hAD: read-only value at address 0x00.
- DEVID_MST, 8'h1D: read-only value at address 0x01.
- PARTID, 8'hF2: read-only value at address 0x02.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- SPI_SCLK  input  1  SPI clock from the controller (asynchronous to clk)
- SPI_CS  input  1  active-low chip select (asynchronous)
- SPI_MOSI  input  1  controller-to-responder data, MSB first
- SPI_MISO  output  1  responder-to-controller data, MSB first
- wr_strobe  output  1  one-clk pulse when a register write commits
- wr_addr  output  8  address of the last committed write
- wr_data  output  8  data of the last committed write
- busy  output  1  high while CS is (synchronized) low

Behaviour:
- Reset: synchronous, active-high; one clock; reset is synchronous and active-high.
  - Outputs: SPI_MISO=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - State IDLE; bit counter 0; writable registers cleared to 0x00.
  - Reset mid-transaction aborts the transaction immediately, with no commit.
- Input sampling and edge detection:
  - SCLK, CS and MOSI each pass through a 2-FF synchronizer; edges are detected from the synchronized value and its previous value.
  - Edge-to-action latency is ≤3 clk cycles.
  - Requirement on the bus: SCLK high and low phases each ≥8 clk cycles (500 kHz SCLK at 100 MHz gives 100).
- Bit handling (mode 0):
  - MOSI is shifted in on each synchronized SCLK rising edge, MSB first.
  - A byte is complete on the 8th rising edge; the bit counter is 3 bits and wraps to 0.
- CS handling:
  - CS falling: state CMD, bit counter 0, busy=1.
  - CS rising in any state: state IDLE, busy=0, SPI_MISO=0; a partial byte is discarded and never committed.
- State machine (transitions on byte complete unless stated):
  - IDLE → CMD: on CS falling.
  - CMD, byte 0x0A → WADDR.
  - CMD, byte 0x0B → RADDR.
  - CMD, any other byte → IGNORE.
  - WADDR → WDATA: latch the address.
  - RADDR → RDATA: latch the address; set load_pending.
  - WDATA: commit write to the latched address, then advance the address (see optional feature).
  - RDATA: advance the address, set load_pending.
  - IGNORE: stays until CS rises; SPI_MISO=0.
- Write commit:
  - If the address is 0x00–0x02 or ≥REG_DEPTH, the register file is unchanged.
  - wr_strobe pulses for exactly 1 clk and wr_addr/wr_data update regardless, so the bench can observe attempted writes.
- Read path:
  - SPI_MISO = tx_shift[7], combinationally from the register.
  - On each synchronized SCLK falling edge: if load_pending, tx_shift ← reg[addr] and load_pending cleared; otherwise tx_shift shifts left with 0 in.
  - Bit 7 of the read byte is therefore valid from the falling edge after the address byte, ahead of the next rising edge.
  - Reads of 0x00–0x02 return the DEVID_AD, DEVID_MST and PARTID parameters; reads at ≥REG_DEPTH return 0x00.
- SPI_MISO is 0 in IDLE, CMD, WADDR, WDATA and IGNORE. It is not tristated.
- Address arithmetic: 8-bit and wraps from 0xFF to 0x00.

Optional Feature:
- Macro: ADXL_SPI_AUTO_INC_EN.
- Defined: burst mode. After each data byte the address increments by 1, with 8-bit wrap.
  - Consecutive writes go to successive registers.
  - Consecutive reads return successive registers; the load for the next byte uses the incremented address.
- Undefined: the address is held.
  - Every further write byte in the same CS frame commits to the same address, one wr_strobe per byte.
  - Further read bytes repeat the same register value.

Test Plan:
- Reset, then frame 0x0B,0x00,0x00 → MISO byte during data phase = 0xAD; busy high only while CS is low; wr_strobe never asserts.
- Frame 0x0A,0x2D,0x02, then frame 0x0B,0x2D,0x00 → one wr_strobe with wr_addr=0x2D, wr_data=0x02; the read returns 0x02.
- Write 0x55 to address 0x01, then read 0x01 → wr_strobe pulses with wr_addr=0x01; the read still returns 0x1D.
- With the macro defined: frame 0x0A,0x20,0x11,0x22,0x33, then frame 0x0B,0x20 plus 3 bytes → reads 0x11,0x22,0x33. Without the macro: the same frames give reg 0x20=0x33, and the reads return 0x33 three times.
- Frame 0x0A,0x10, 4 data bits, then CS high → no wr_strobe and reg 0x10 unchanged; the next frame 0x0B,0x10,0x00 decodes correctly.
- Frame 0x07,0x00,0x00 → state IGNORE, MISO=0 throughout, no strobe; assert rst mid-frame → all outputs 0 and writable registers cleared.
